// File: rtl/popcount21_unary_tx_pkg.sv
// Shared definitions for the popcount21 family: default frame geometry,
// the transmitter state encoding and the default-width count type.
package popcount_pkg;

    // Frame length in beats; also the largest count a frame can carry.
    localparam int N_BITS_DEFAULT = 21;

    // Count width; 2**CNT_W must exceed N_BITS so every legal count fits.
    localparam int CNT_W_DEFAULT  = 5;

    // IDLE waits for a count, RUN streams one frame.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Population count at the default width.
    typedef logic [CNT_W_DEFAULT-1:0] count_t;

endpackage : popcount_pkg

// File: rtl/popcount21_unary_tx_if.sv
// Handshake bundle for the unary transmitter: a count-in channel, a
// one-bit beat-out channel and two status flags.
//   master : the transmitter itself (drives ready, beats and status)
//   slave  : the environment (offers counts, accepts beats)
interface popcount21_unary_tx_if
    import popcount_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) ();

    logic             in_valid;
    logic             in_ready;
    logic [CNT_W-1:0] in_count;
    logic             out_valid;
    logic             out_ready;
    logic             out_bit;
    logic             out_first;
    logic             out_last;
    logic             sat_pulse;
    logic             busy;

    modport master (
        input  in_valid,
        input  in_count,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_bit,
        output out_first,
        output out_last,
        output sat_pulse,
        output busy
    );

    modport slave (
        output in_valid,
        output in_count,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_bit,
        input  out_first,
        input  out_last,
        input  sat_pulse,
        input  busy
    );

endinterface : popcount21_unary_tx_if

// File: rtl/popcount21_unary_tx_unary_beat_gen.sv
// Combinational beat generator. Given the beat index, the clamped count and
// the running accumulator it produces the bit for that beat and the
// accumulator value after it. Kept free of state so a popcount21 block can
// reuse it in a loopback check.
//   thermometer (i_spread=0): bit = (k < c), accumulator passes through
//   spread      (i_spread=1): Bresenham step, acc' = acc + c, emit a one and
//                             wrap by N_BITS whenever acc' reaches N_BITS
module unary_beat_gen
    import popcount_pkg::*;
#(
    parameter int N_BITS = N_BITS_DEFAULT,
    parameter int CNT_W  = CNT_W_DEFAULT
) (
    input  logic             i_spread,
    input  logic [CNT_W-1:0] i_k,
    input  logic [CNT_W-1:0] i_c,
    input  logic [CNT_W:0]   i_acc,
    output logic             o_bit,
    output logic [CNT_W:0]   o_acc
);

    // One extra accumulator bit: acc < N_BITS and c <= N_BITS, so the sum
    // stays below 2*N_BITS, which fits in CNT_W+1 bits.
    localparam logic [CNT_W:0] ACC_LIMIT = (CNT_W+1)'(N_BITS);

    logic [CNT_W:0] w_sum;

    assign w_sum = i_acc + {1'b0, i_c};

    // Select thermometer compare or Bresenham step for this beat.
    always_comb begin
        o_bit = 1'b0;
        o_acc = i_acc;
        if (i_spread) begin
            if (w_sum >= ACC_LIMIT) begin
                o_bit = 1'b1;
                o_acc = w_sum - ACC_LIMIT;
            end else begin
                o_bit = 1'b0;
                o_acc = w_sum;
            end
        end else begin
            o_bit = (i_k < i_c);
        end
    end

endmodule : unary_beat_gen

// File: rtl/popcount21_unary_tx.sv
// Unary transmitter: accepts a population count and replays it as an
// N_BITS-beat serial frame holding exactly min(count, N_BITS) ones, either
// ones-first (thermometer) or evenly spread (Bresenham). Every output is a
// register; in_ready depends only on state, never on out_ready.
module popcount21_unary_tx
    import popcount_pkg::*;
#(
    parameter int N_BITS = N_BITS_DEFAULT,
    parameter int CNT_W  = CNT_W_DEFAULT,
    parameter int SPREAD = 0
) (
    input logic                 clk,
    input logic                 rst_n,
    popcount21_unary_tx_if.master bus
);

    localparam logic [CNT_W-1:0] COUNT_LIMIT = CNT_W'(N_BITS);
    localparam logic [CNT_W-1:0] LAST_K      = CNT_W'(N_BITS - 1);
    localparam logic             MODE_SPREAD = (SPREAD != 0);

    state_t           r_state;
    logic [CNT_W-1:0] r_k;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W:0]   r_acc;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_out_bit;
    logic             r_out_first;
    logic             r_out_last;
    logic             r_sat_pulse;
    logic             r_busy;

    logic             w_accept;
    logic             w_beat_take;
    logic             w_sat;
    logic [CNT_W-1:0] w_clamped;
    logic [CNT_W-1:0] w_gen_k;
    logic [CNT_W-1:0] w_gen_c;
    logic [CNT_W:0]   w_gen_acc_in;
    logic [CNT_W:0]   w_gen_acc_out;
    logic             w_gen_bit;

    assign w_accept    = (r_state == IDLE) && r_in_ready && bus.in_valid;
    assign w_beat_take = (r_state == RUN) && r_out_valid && bus.out_ready;
    assign w_sat       = (bus.in_count > COUNT_LIMIT);
    assign w_clamped   = w_sat ? COUNT_LIMIT : bus.in_count;

    // Feed the generator the beat that will be shown after the next edge:
    // beat 0 from a fresh accumulator while idle, otherwise beat k+1.
    // r_acc holds the accumulator after the beat currently on out_bit,
    // so a single generator suffices and the bit can be registered.
    always_comb begin
        w_gen_k      = '0;
        w_gen_c      = w_clamped;
        w_gen_acc_in = '0;
        if (r_state == RUN) begin
            w_gen_k      = r_k + CNT_W'(1);
            w_gen_c      = r_count;
            w_gen_acc_in = r_acc;
        end
    end

    unary_beat_gen #(
        .N_BITS (N_BITS),
        .CNT_W  (CNT_W)
    ) u_beat_gen (
        .i_spread (MODE_SPREAD),
        .i_k      (w_gen_k),
        .i_c      (w_gen_c),
        .i_acc    (w_gen_acc_in),
        .o_bit    (w_gen_bit),
        .o_acc    (w_gen_acc_out)
    );

    // Frame FSM with beat counter, accumulator and registered handshake.
    // Reset drops everything at once, so an interrupted frame ends with no
    // out_last. in_ready stays low for the first cycle after reset and
    // comes back the cycle after the last beat is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_k         <= '0;
            r_count     <= '0;
            r_acc       <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_bit   <= 1'b0;
            r_out_first <= 1'b0;
            r_out_last  <= 1'b0;
            r_sat_pulse <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_sat_pulse <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        r_state     <= RUN;
                        r_in_ready  <= 1'b0;
                        r_busy      <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_count     <= w_clamped;
                        r_k         <= '0;
                        r_acc       <= w_gen_acc_out;
                        r_out_bit   <= w_gen_bit;
                        r_out_first <= 1'b1;
                        r_out_last  <= (LAST_K == '0);
                        r_sat_pulse <= w_sat;
                    end
                end
                RUN: begin
                    if (w_beat_take) begin
                        if (r_out_last) begin
                            r_state     <= IDLE;
                            r_in_ready  <= 1'b1;
                            r_busy      <= 1'b0;
                            r_out_valid <= 1'b0;
                            r_out_bit   <= 1'b0;
                            r_out_first <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_k         <= '0;
                            r_acc       <= '0;
                        end else begin
                            r_k         <= w_gen_k;
                            r_acc       <= w_gen_acc_out;
                            r_out_bit   <= w_gen_bit;
                            r_out_first <= 1'b0;
                            r_out_last  <= (w_gen_k == LAST_K);
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_bit   = r_out_bit;
    assign bus.out_first = r_out_first;
    assign bus.out_last  = r_out_last;
    assign bus.sat_pulse = r_sat_pulse;
    assign bus.busy      = r_busy;

endmodule : popcount21_unary_tx

// File: tb/tb_popcount21_unary_tx.sv
// Testbench for popcount21_unary_tx: a thermometer instance and a spread
// instance run side by side on identical stimulus. Expected beats come from
// closed-form formulas rather than a copy of the accumulator datapath.
module tb_popcount21_unary_tx;
    import popcount_pkg::*;

    localparam int N  = 21;
    localparam int CW = 5;

    logic clk = 1'b0;
    logic rst_n;

    int nChecks = 0;
    int nFails  = 0;

    // 10-time-unit clock; stimulus and sampling happen on the falling edge.
    always #5 clk = ~clk;

    popcount21_unary_tx_if #(.CNT_W(CW)) ifT ();
    popcount21_unary_tx_if #(.CNT_W(CW)) ifS ();

    popcount21_unary_tx #(.N_BITS(N), .CNT_W(CW), .SPREAD(0)) dutThermo (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifT)
    );

    popcount21_unary_tx #(.N_BITS(N), .CNT_W(CW), .SPREAD(1)) dutSpread (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifS)
    );

    // Single comparison point: counts every check, reports any difference.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Drive the same inputs onto both instances.
    task automatic driveIn(input logic v, input logic [CW-1:0] c, input logic r);
        ifT.in_valid  = v;
        ifT.in_count  = c;
        ifT.out_ready = r;
        ifS.in_valid  = v;
        ifS.in_count  = c;
        ifS.out_ready = r;
    endtask

    // Reference beat: thermometer is k<c; spread is the number of multiples
    // of N crossed between k*c and (k+1)*c, which places c ones evenly.
    function automatic int expBit(input int spread, input int c, input int k);
        if (spread == 0) return (k < c) ? 1 : 0;
        return ((k + 1) * c) / N - (k * c) / N;
    endfunction

    // Bounded wait until both instances offer in_ready.
    task automatic waitReady(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (ifT.in_ready === 1'b1 && ifS.in_ready === 1'b1) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
        checkOutput("inReadyTimeout", 0, 1);
    endtask

    // Send one count and walk the whole frame, checking every displayed
    // beat of both instances. With backpressure, out_ready and in_valid are
    // randomised; a stalled beat is re-checked against the same expected
    // values, which also proves it is held stable.
    task automatic applyStimulus(input int cnt, input bit backpressure);
        bit   ok;
        int   expC;
        int   beat;
        int   cyc;
        int   onesT;
        int   onesS;
        logic rdy;
        logic bitT;
        logic bitS;
        logic [CW-1:0] cntBits;

        expC    = (cnt > N) ? N : cnt;
        cntBits = cnt[CW-1:0];
        waitReady(ok);
        if (!ok) return;
        driveIn(1'b1, cntBits, 1'b1);
        @(negedge clk);
        // in_count changes right after the accept edge; it must not matter.
        driveIn(1'b0, CW'($urandom_range(0, 31)), 1'b1);

        beat  = 0;
        cyc   = 0;
        onesT = 0;
        onesS = 0;
        while (beat < N && cyc < 400) begin
            checkOutput($sformatf("c%0d.validT[%0d]", cnt, beat), ifT.out_valid, 1);
            checkOutput($sformatf("c%0d.validS[%0d]", cnt, beat), ifS.out_valid, 1);
            checkOutput($sformatf("c%0d.inReady[%0d]", cnt, beat), ifT.in_ready | ifS.in_ready, 0);
            checkOutput($sformatf("c%0d.busy[%0d]", cnt, beat), ifT.busy & ifS.busy, 1);
            checkOutput($sformatf("c%0d.satT[%0d]", cnt, cyc), ifT.sat_pulse, (cyc == 0 && cnt > N) ? 1 : 0);
            checkOutput($sformatf("c%0d.satS[%0d]", cnt, cyc), ifS.sat_pulse, (cyc == 0 && cnt > N) ? 1 : 0);
            checkOutput($sformatf("c%0d.bitT[%0d]", cnt, beat), ifT.out_bit, expBit(0, expC, beat));
            checkOutput($sformatf("c%0d.bitS[%0d]", cnt, beat), ifS.out_bit, expBit(1, expC, beat));
            checkOutput($sformatf("c%0d.firstT[%0d]", cnt, beat), ifT.out_first, (beat == 0) ? 1 : 0);
            checkOutput($sformatf("c%0d.firstS[%0d]", cnt, beat), ifS.out_first, (beat == 0) ? 1 : 0);
            checkOutput($sformatf("c%0d.lastT[%0d]", cnt, beat), ifT.out_last, (beat == N - 1) ? 1 : 0);
            checkOutput($sformatf("c%0d.lastS[%0d]", cnt, beat), ifS.out_last, (beat == N - 1) ? 1 : 0);
            bitT = ifT.out_bit;
            bitS = ifS.out_bit;
            rdy  = backpressure ? 1'($urandom_range(0, 1)) : 1'b1;
            if (backpressure)
                driveIn(1'($urandom_range(0, 1)), CW'(1), rdy);
            else
                driveIn(1'b0, CW'(0), rdy);
            @(negedge clk);
            if (rdy) begin
                onesT += int'(bitT);
                onesS += int'(bitS);
                beat++;
            end
            cyc++;
        end
        driveIn(1'b0, CW'(0), 1'b1);
        if (beat < N) checkOutput("frameTimeout", beat, N);

        // Loopback popcount of the collected frame, then the idle bubble.
        checkOutput($sformatf("c%0d.onesT", cnt), onesT, expC);
        checkOutput($sformatf("c%0d.onesS", cnt), onesS, expC);
        if (!backpressure) checkOutput($sformatf("c%0d.frameCycles", cnt), cyc, N);
        checkOutput($sformatf("c%0d.bubbleValid", cnt), ifT.out_valid | ifS.out_valid, 0);
        checkOutput($sformatf("c%0d.bubbleReady", cnt), ifT.in_ready & ifS.in_ready, 1);
        checkOutput($sformatf("c%0d.bubbleBusy", cnt), ifT.busy | ifS.busy, 0);
    endtask

    // Every output of both instances must be zero.
    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".validT"}, ifT.out_valid, 0);
        checkOutput({tag, ".validS"}, ifS.out_valid, 0);
        checkOutput({tag, ".bits"}, ifT.out_bit | ifS.out_bit, 0);
        checkOutput({tag, ".first"}, ifT.out_first | ifS.out_first, 0);
        checkOutput({tag, ".last"}, ifT.out_last | ifS.out_last, 0);
        checkOutput({tag, ".sat"}, ifT.sat_pulse | ifS.sat_pulse, 0);
        checkOutput({tag, ".busy"}, ifT.busy | ifS.busy, 0);
        checkOutput({tag, ".inReady"}, ifT.in_ready | ifS.in_ready, 0);
    endtask

    // Start a count-12 frame, reset at beat 9, then send count 3.
    task automatic midFrameReset();
        bit ok;
        waitReady(ok);
        if (!ok) return;
        driveIn(1'b1, CW'(12), 1'b1);
        @(negedge clk);
        driveIn(1'b0, CW'(0), 1'b1);
        repeat (9) @(negedge clk);
        checkOutput("abort.beat9BitT", ifT.out_bit, 1);
        checkOutput("abort.beat9Last", ifT.out_last | ifS.out_last, 0);
        checkOutput("abort.beat9Busy", ifT.busy & ifS.busy, 1);
        rst_n = 1'b0;
        #1;
        checkAllZero("abort.async");
        repeat (2) begin
            @(negedge clk);
            checkAllZero("abort.held");
        end
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("abort.readyAfter", ifT.in_ready & ifS.in_ready, 1);
        checkOutput("abort.validAfter", ifT.out_valid | ifS.out_valid, 0);
        applyStimulus(3, 1'b0);
    endtask

    // Main sequence.
    initial begin
        rst_n = 1'b1;
        driveIn(1'b0, CW'(0), 1'b0);
        #2;
        rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checkAllZero("reset");
        end
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("reset.readyAfter", ifT.in_ready & ifS.in_ready, 1);
        checkOutput("reset.validAfter", ifT.out_valid | ifS.out_valid, 0);

        $display("[TB] thermometer and spread frames, count 7 and 5");
        applyStimulus(7, 1'b0);
        applyStimulus(5, 1'b0);

        $display("[TB] sweep of counts 0..21");
        for (int c = 0; c <= N; c++) applyStimulus(c, 1'b0);

        $display("[TB] saturation");
        applyStimulus(27, 1'b0);
        applyStimulus(31, 1'b0);
        applyStimulus(21, 1'b0);

        $display("[TB] backpressure with stray in_valid");
        applyStimulus(10, 1'b1);
        applyStimulus(10, 1'b1);
        applyStimulus(16, 1'b1);

        $display("[TB] mid-frame reset");
        midFrameReset();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    // Guard against a stuck run.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule : tb_popcount21_unary_tx
